escaneo_teclado: RTL and testbench

- Scans a 4x4 matrix keypad (Pmod KYPD type) by driving one column low at a time and reading the four row lines.
- Debounces each detected key and reports a 4-bit key code with a one-cycle valid strobe.
- Sits alongside the 7-segment display path. It is the input-side reader that complements the active-low one-hot anode drive, so user keys can feed the display/control logic.

---
 rtl/escaneo_teclado_if.sv | 25 ++
 rtl/escaneo_teclado.sv | 148 ++++++++++++++
 tb/tb_escaneo_teclado.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/escaneo_teclado_if.sv
// Keypad-side bundle: row sense lines in, column drive and accepted-key report out.
// The scanner takes the master modport; the keypad/consumer side takes slave.
interface escaneo_teclado_if;
    logic [3:0] Fila;
    logic [3:0] Columna;
    logic [3:0] Tecla;
    logic       Valida;
    logic       Presionada;

    modport master (
        input  Fila,
        output Columna,
        output Tecla,
        output Valida,
        output Presionada
    );

    modport slave (
        output Fila,
        input  Columna,
        input  Tecla,
        input  Valida,
        input  Presionada
    );
endinterface

// File: rtl/escaneo_teclado.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, samples synchronized rows,
// picks one key per frame and debounces press/release over DEB_SCANS whole frames.
module escaneo_teclado #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned DEB_SCANS = 4
) (
    input logic               Clk,
    input logic               Reset,
    escaneo_teclado_if.master kp
);

    localparam int unsigned   DivW    = $clog2(SCAN_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [3:0]    DebCnt  = 4'(DEB_SCANS);
    localparam bit            DebOne  = (DEB_SCANS == 1);

    typedef enum logic [1:0] {StIdle, StCand, StHeld} state_e;

    logic [3:0]      fila_s1_q, fila_s2_q;
    logic [DivW-1:0] div_q;
    logic [1:0]      col_idx_q;
    logic [3:0]      col_q;
    logic            acc_hit_q;
    logic [3:0]      acc_code_q;
    state_e          state_q;
    logic [3:0]      cand_q;
    logic [3:0]      cnt_q;
    logic [3:0]      rel_q;
    logic [3:0]      tecla_q;
    logic            valida_q;
    logic            pres_q;

    logic            tick;
    logic            frame_end;
    logic            col_hit;
    logic [1:0]      col_row;
    logic [3:0]      col_code;
    logic            frame_hit;
    logic [3:0]      frame_code;

    always_comb begin
        tick      = (div_q == DivLast);
        frame_end = tick && (col_idx_q == 2'd3);
        col_hit   = 1'b0;
        col_row   = 2'd0;
        // Descending walk so the lowest active row is the one that sticks.
        for (int r = 3; r >= 0; r--) begin
            if (!fila_s2_q[r]) begin
                col_hit = 1'b1;
                col_row = 2'(r);
            end
        end
        col_code   = {col_row, col_idx_q};
        frame_hit  = acc_hit_q | col_hit;
        frame_code = acc_hit_q ? acc_code_q : col_code;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fila_s1_q  <= 4'hF;
            fila_s2_q  <= 4'hF;
            div_q      <= '0;
            col_idx_q  <= 2'd0;
            col_q      <= 4'b1110;
            acc_hit_q  <= 1'b0;
            acc_code_q <= 4'h0;
            state_q    <= StIdle;
            cand_q     <= 4'h0;
            cnt_q      <= 4'd0;
            rel_q      <= 4'd0;
            tecla_q    <= 4'h0;
            valida_q   <= 1'b0;
            pres_q     <= 1'b0;
        end else begin
            fila_s1_q <= kp.Fila;
            fila_s2_q <= fila_s1_q;
            valida_q  <= 1'b0;
            if (!tick) begin
                div_q <= div_q + 1'b1;
            end else begin
                div_q     <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                col_q     <= {col_q[2:0], col_q[3]};
                if (!frame_end) begin
                    // Earlier columns win, so only the first hit of a frame is kept.
                    if (!acc_hit_q && col_hit) begin
                        acc_hit_q  <= 1'b1;
                        acc_code_q <= col_code;
                    end
                end else begin
                    acc_hit_q  <= 1'b0;
                    acc_code_q <= 4'h0;
                    unique case (state_q)
                        StIdle: begin
                            if (frame_hit) begin
                                if (DebOne) begin
                                    tecla_q  <= frame_code;
                                    pres_q   <= 1'b1;
                                    valida_q <= 1'b1;
                                    rel_q    <= 4'd0;
                                    state_q  <= StHeld;
                                end else begin
                                    cand_q  <= frame_code;
                                    cnt_q   <= 4'd1;
                                    state_q <= StCand;
                                end
                            end
                        end
                        StCand: begin
                            if (!frame_hit) begin
                                state_q <= StIdle;
                            end else if (frame_code != cand_q) begin
                                cand_q <= frame_code;
                                cnt_q  <= 4'd1;
                            end else if (cnt_q + 4'd1 == DebCnt) begin
                                tecla_q  <= cand_q;
                                pres_q   <= 1'b1;
                                valida_q <= 1'b1;
                                rel_q    <= 4'd0;
                                state_q  <= StHeld;
                            end else begin
                                cnt_q <= cnt_q + 4'd1;
                            end
                        end
                        StHeld: begin
                            if (frame_hit) begin
                                rel_q <= 4'd0;
                            end else if (rel_q + 4'd1 == DebCnt) begin
                                rel_q   <= 4'd0;
                                pres_q  <= 1'b0;
                                state_q <= StIdle;
                            end else begin
                                rel_q <= rel_q + 4'd1;
                            end
                        end
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end
    end

    assign kp.Columna    = col_q;
    assign kp.Tecla      = tecla_q;
    assign kp.Valida     = valida_q;
    assign kp.Presionada = pres_q;

endmodule

// File: tb/tb_escaneo_teclado.sv
// Bench for escaneo_teclado: keypad modelled as a set of pressed keys shorting rows to columns;
// hand-computed frame table, a reset-mid-press sequence and random frames against a history model.
module tb_escaneo_teclado;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int unsigned FRAME    = 4 * SCAN_DIV;

    localparam logic [15:0] K2  = 16'h0004;
    localparam logic [15:0] K3  = 16'h0008;
    localparam logic [15:0] K5  = 16'h0020;
    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K14 = 16'h4000;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] keys;
    logic [3:0]  fila_m;

    int checks   = 0;
    int failures = 0;

    escaneo_teclado_if kp ();

    escaneo_teclado #(
        .SCAN_DIV (SCAN_DIV),
        .DEB_SCANS(DEB)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .kp   (kp)
    );

    always #5 Clk = ~Clk;

    // A pressed key at (r,c) pulls row r low whenever column c is driven low.
    always_comb begin
        fila_m = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r+c] && !kp.Columna[c]) fila_m[r] = 1'b0;
            end
        end
    end
    assign kp.Fila = fila_m;

    typedef struct {
        logic [15:0] k;
        logic        v;
        logic [3:0]  t;
        logic        p;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: per-frame history of {hit, code}.
    logic       qhit[$];
    logic [3:0] qcode[$];
    logic       m_pres;
    logic [3:0] m_tecla;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    task automatic add(input logic [15:0] k, input logic v, input logic [3:0] t, input logic p,
                       input int n);
        vec_t e;
        e.k = k; e.v = v; e.t = t; e.p = p;
        for (int i = 0; i < n; i++) tbl.push_back(e);
    endtask

    task automatic do_reset();
        keys  = 16'h0;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("reset_columna", kp.Columna, 4'b1110);
        chk("reset_tecla", kp.Tecla, 4'h0);
        chk("reset_valida", kp.Valida, 1'b0);
        chk("reset_presionada", kp.Presionada, 1'b0);
    endtask

    // Called at cycle 0 of a frame; returns at cycle 0 of the next one.
    task automatic run_frame(input logic [15:0] k, input logic ev, input logic [3:0] et,
                             input logic ep);
        logic [3:0] ec;
        keys = k;
        for (int i = 0; i < int'(FRAME); i++) begin
            ec = ~(4'b0001 << (i / int'(SCAN_DIV)));
            chk("columna", kp.Columna, ec);
            if (i > 0) chk("valida_quiet", kp.Valida, 1'b0);
            @(posedge Clk); #1;
        end
        chk("valida", kp.Valida, ev);
        chk("tecla", kp.Tecla, et);
        chk("presionada", kp.Presionada, ep);
    endtask

    task automatic model_frame(input logic [15:0] k, output logic ev, output logic [3:0] et,
                               output logic ep);
        logic       hit;
        logic [3:0] code;
        int         run;
        hit  = 1'b0;
        code = 4'h0;
        for (int c = 0; c < 4 && !hit; c++) begin
            for (int r = 0; r < 4 && !hit; r++) begin
                if (k[4*r+c]) begin
                    hit  = 1'b1;
                    code = 4'(4 * r + c);
                end
            end
        end
        qhit.push_back(hit);
        qcode.push_back(code);
        ev  = 1'b0;
        run = 0;
        if (!m_pres) begin
            for (int j = qhit.size() - 1; j >= 0; j--) begin
                if (!qhit[j] || qcode[j] != code) break;
                run++;
            end
            if (hit && run >= int'(DEB)) begin
                ev      = 1'b1;
                m_pres  = 1'b1;
                m_tecla = code;
            end
        end else begin
            for (int j = qhit.size() - 1; j >= 0; j--) begin
                if (qhit[j]) break;
                run++;
            end
            if (run >= int'(DEB)) m_pres = 1'b0;
        end
        et = m_tecla;
        ep = m_pres;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ev, ep;
        logic [3:0] et;
        logic [15:0] rk;
        int          hold;

        // Idle, single press/release, bounce, two keys, key switch while held, re-press.
        add(16'h0, 0, 4'h0, 0, 10);
        add(K9, 0, 4'h0, 0, 2); add(K9, 1, 4'h9, 1, 1); add(K9, 0, 4'h9, 1, 3);
        add(16'h0, 0, 4'h9, 1, 2); add(16'h0, 0, 4'h9, 0, 1);
        add(K3, 0, 4'h9, 0, 2); add(16'h0, 0, 4'h9, 0, 1); add(K3, 0, 4'h9, 0, 2);
        add(K3, 1, 4'h3, 1, 1); add(16'h0, 0, 4'h3, 1, 2); add(16'h0, 0, 4'h3, 0, 1);
        add(K5 | K14, 0, 4'h3, 0, 2); add(K5 | K14, 1, 4'h5, 1, 1);
        add(16'h0, 0, 4'h5, 1, 2); add(16'h0, 0, 4'h5, 0, 1);
        add(K9, 0, 4'h5, 0, 2); add(K9, 1, 4'h9, 1, 1); add(K2, 0, 4'h9, 1, 2);
        add(16'h0, 0, 4'h9, 1, 2); add(16'h0, 0, 4'h9, 0, 1);
        add(K2, 0, 4'h9, 0, 2); add(K2, 1, 4'h2, 1, 1);
        add(16'h0, 0, 4'h2, 1, 2); add(16'h0, 0, 4'h2, 0, 1);

        do_reset();
        for (int n = 0; n < tbl.size(); n++) run_frame(tbl[n].k, tbl[n].v, tbl[n].t, tbl[n].p);

        // Reset partway through the second frame of a candidate press.
        run_frame(K9, 0, 4'h2, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
        end
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("midreset_columna", kp.Columna, 4'b1110);
        chk("midreset_valida", kp.Valida, 1'b0);
        chk("midreset_tecla", kp.Tecla, 4'h0);
        chk("midreset_presionada", kp.Presionada, 1'b0);
        run_frame(K9, 0, 4'h0, 0);
        run_frame(K9, 0, 4'h0, 0);
        run_frame(K9, 1, 4'h9, 1);

        // Random frames against the history model.
        do_reset();
        qhit.delete();
        qcode.delete();
        m_pres  = 1'b0;
        m_tecla = 4'h0;
        hold    = 0;
        rk      = 16'h0;
        for (int f = 0; f < 80; f++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: rk = 16'h0;
                    4, 5, 6, 7: rk = 16'h1 << $urandom_range(0, 15);
                    default:    rk = (16'h1 << $urandom_range(0, 15)) |
                                     (16'h1 << $urandom_range(0, 15));
                endcase
                hold = int'($urandom_range(1, 5));
            end
            hold--;
            model_frame(rk, ev, et, ep);
            run_frame(rk, ev, et, ep);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
